// File: rtl/median_window_ctrl.sv
`default_nettype none
// median_window_ctrl: raster pixels -> 3x3 windows -> shared serial median engine -> valid/ready median.
// Revision 1.0
module median_window_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    output logic             pix_ready,
    output logic             m_load,
    output logic [PIX_W-1:0] m_data,
    output logic             m_start,
    input  logic             m_done,
    input  logic [PIX_W-1:0] m_result,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    input  logic             out_ready,
    output logic             frame_done,
    output logic             err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(2);
    localparam logic [RW-1:0] ROW_WIN   = RW'(2);
    localparam logic [TW-1:0] TIME_LIM  = TW'(TIMEOUT);
    localparam logic [3:0]    K_LAST    = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [3:0]       k;
    logic [TW-1:0]    timer;
    logic             last_win;
    logic [PIX_W-1:0] linebuf0 [IMG_W];
    logic [PIX_W-1:0] linebuf1 [IMG_W];
    logic [PIX_W-1:0] win      [9];

    logic             accept;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;
    logic             win_full;
    logic             timeout_hit;

    // A start-of-frame pixel is positioned at (0,0) regardless of the running counters.
    assign cur_col     = pix_sof ? '0 : col;
    assign cur_row     = pix_sof ? '0 : row;
    assign accept      = (state == S_IDLE) && pix_valid;
    assign win_full    = (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);
    assign timeout_hit = (timer == TIME_LIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        m_load    = 1'b0;
        m_data    = '0;
        m_start   = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid && win_full) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                m_load = 1'b1;
                m_data = win[k];
                if (k == K_LAST) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                m_start   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A result in the same cycle as the timeout still counts as success.
                if (m_done) begin
                    state_nxt = S_OUT;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            k          <= '0;
            timer      <= '0;
            last_win   <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    k <= '0;
                    if (pix_valid) begin
                        last_win <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
                        if (cur_col == COL_LAST) begin
                            col <= '0;
                            row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                        end else begin
                            col <= cur_col + 1'b1;
                            row <= cur_row;
                        end
                    end
                end
                S_LOAD: begin
                    k <= k + 1'b1;
                end
                S_START: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (m_done) begin
                        out_data <= m_result;
                    end else if (timeout_hit) begin
                        err        <= 1'b1;
                        frame_done <= last_win;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        frame_done <= last_win;
                    end
                end
                default: ;
            endcase
        end
    end

    // Window and line buffers carry no reset; their contents before the third line are never used.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r*3]     <= win[r*3+1];
                win[r*3+1]   <= win[r*3+2];
            end
            win[2]            <= linebuf1[cur_col];
            win[5]            <= linebuf0[cur_col];
            win[8]            <= pix_data;
            linebuf1[cur_col] <= linebuf0[cur_col];
            linebuf0[cur_col] <= pix_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_median_window_ctrl.sv
`default_nettype none
// tb_median_window_ctrl: scoreboard bench for median_window_ctrl on a 4x4 frame with a behavioural engine.
// Revision 1.0
module tb_median_window_ctrl;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int PIX_W   = 8;
    localparam int TIMEOUT = 15;
    localparam int BUDGET  = 400;

    logic             clk = 1'b0;
    logic             reset;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic             pix_ready;
    logic             m_load;
    logic [PIX_W-1:0] m_data;
    logic             m_start;
    logic             m_done;
    logic [PIX_W-1:0] m_result;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;
    logic             out_ready;
    logic             frame_done;
    logic             err;

    always #5 clk = ~clk;

    median_window_ctrl #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .PIX_W   (PIX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .m_load     (m_load),
        .m_data     (m_data),
        .m_start    (m_start),
        .m_done     (m_done),
        .m_result   (m_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .err        (err)
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    int               fd_cnt   = 0;
    int               win_cnt  = 0;
    bit               hang     = 1'b0;
    logic [PIX_W-1:0] exp_q [$];
    logic [PIX_W-1:0] samples [$];
    logic [PIX_W-1:0] last_win [9];
    logic [PIX_W-1:0] exp_win  [9] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural engine: collects samples, returns the 5th smallest three cycles after start.
    initial begin : engine
        int               cnt;
        logic [PIX_W-1:0] s [$];
        cnt      = 0;
        m_done   = 1'b0;
        m_result = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (reset) begin
                samples.delete();
                cnt = 0;
            end else begin
                if (m_load) begin
                    samples.push_back(m_data);
                    chk("load_while_ready", 32'(pix_ready), 32'd0);
                    chk("load_with_start", 32'(m_start), 32'd0);
                end
                if (m_start) begin
                    chk("load_count", 32'(samples.size()), 32'd9);
                    for (int i = 0; i < 9; i++) begin
                        last_win[i] = (i < samples.size()) ? samples[i] : '0;
                    end
                    s = samples;
                    s.sort();
                    m_result = (s.size() == 9) ? s[4] : '1;
                    samples.delete();
                    win_cnt++;
                    cnt = hang ? 0 : 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : monitor
        logic [PIX_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (frame_done) begin
                    fd_cnt++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %0d, expected no output", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("median", 32'(out_data), 32'(e));
                    end
                end
            end
        end
    end

    task automatic send_pix(input logic [PIX_W-1:0] d, input logic sof);
        int n;
        n         = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        do begin
            @(negedge clk);
            n++;
        end while (!pix_ready && n < BUDGET);
        if (!pix_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL pix_accept: pixel %0d not accepted after %0d cycles, expected acceptance", d, n);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 1; i <= IMG_W * IMG_H; i++) begin
            send_pix(PIX_W'(i), i == 1);
        end
    endtask

    task automatic push_medians();
        exp_q.push_back(8'd6);
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd10);
        exp_q.push_back(8'd11);
    endtask

    task automatic wait_fd(input int base, input string name);
        int n;
        n = 0;
        while (fd_cnt == base && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_frame_done"}, 32'(fd_cnt - base), 32'd1);
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int wb;
        int n;
        int loads;
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        pix_sof   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_m_load", 32'(m_load), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Plain frame, with the first loaded window checked sample by sample.
        base = fd_cnt;
        wb   = win_cnt;
        push_medians();
        fork
            send_frame();
            begin
                n = 0;
                while (win_cnt == wb && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                chk("first_window_seen", 32'(win_cnt != wb), 32'd1);
                for (int i = 0; i < 9; i++) begin
                    chk($sformatf("first_window_%0d", i), 32'(last_win[i]), 32'(exp_win[i]));
                end
            end
        join
        wait_fd(base, "normal");

        // Downstream stall on the first median.
        base      = fd_cnt;
        out_ready = 1'b0;
        push_medians();
        fork
            send_frame();
            begin
                n = 0;
                while (!out_valid && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'd6);
                    chk("hold_no_ready", 32'(pix_ready), 32'd0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_fd(base, "stall");

        // Partial frame aborted by a start-of-frame on the 7th pixel.
        base = fd_cnt;
        for (int i = 1; i <= 6; i++) begin
            send_pix(PIX_W'(i), i == 1);
        end
        push_medians();
        send_frame();
        wait_fd(base, "sof_abort");

        // Hung engine: every window times out after exactly TIMEOUT+1 wait cycles.
        hang = 1'b1;
        base = fd_cnt;
        fork
            send_frame();
            begin
                n = 0;
                while (!m_start && n < BUDGET) begin
                    @(negedge clk);
                    n++;
                end
                chk("err_before_timeout", 32'(err), 32'd0);
                n = 0;
                @(negedge clk);
                while (!pix_ready && n < BUDGET) begin
                    n++;
                    @(negedge clk);
                end
                chk("wait_cycles", 32'(n), 32'(TIMEOUT + 1));
                chk("err_set", 32'(err), 32'd1);
            end
        join
        wait_fd(base, "hang");
        repeat (10) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        hang = 1'b0;

        // Reset while the fifth sample (k=4) is being loaded.
        base = fd_cnt;
        for (int i = 1; i <= 11; i++) begin
            send_pix(PIX_W'(i), i == 1);
        end
        n     = 0;
        loads = 0;
        while (loads < 5 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (m_load) begin
                loads++;
            end
        end
        chk("reached_k4", 32'(loads), 32'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_m_load", 32'(m_load), 32'd0);
        chk("abort_pix_ready", 32'(pix_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        push_medians();
        send_frame();
        wait_fd(base, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
